alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Registered controller that accepts one ALU command per valid/ready handshake and runs it through a combinational 4-bit ALU core for 1..N passes.
- Optionally chains each pass's low nibble back in as operand A.
- Holds the 8-bit result until acknowledged.
- Sits between the switch/key input logic and the LEDR/HEX display path, replacing direct KEY-decoded function select.

Parameters:
- ITER_W, 3, width of the pass-count field; maximum passes = 2^ITER_W - 1.

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  command present
- req_ready  out  1  sequencer can accept a command
- op  in  3  function code
- a  in  4  operand A
- b  in  4  operand B
- iters  in  ITER_W  pass count; 0 is treated as 1
- chain  in  1  1 = feed result[3:0] back as A after each pass
- result  out  8  current result register
- result_valid  out  1  final result available
- result_ack  in  1  consumer takes the result
- busy  out  1  high in EXEC or HOLD
- pass_cnt  out  ITER_W  passes completed in the current command
- ovf  out  1  sticky carry flag for the command

Behaviour:
- Reset (async, resetn=0), all effective immediately:
  - state=IDLE; result=8'h00, result_valid=0, busy=0, pass_cnt=0, ovf=0, req_ready=1.
  - Internal A/B/op/chain/target registers cleared.
- ALU core functions (combinational; A, B are the latched operands):
  - op0: {3'b0, A+B} (5-bit sum).
  - op1: same value as op0.
  - op2: {~(A&B), ~(A^B)}.
  - op3: 8'h0F if |{A,B} else 8'h00.
  - op4: 8'hF0 if B has odd parity and A has exactly two bits set, else 8'h00.
  - op5: {B, ~A}.
  - op6, op7: 8'h00.
- States: IDLE, EXEC, HOLD.
- IDLE:
  - req_ready=1.
  - On req_valid at a clock edge (the accept edge): latch a, b, op, chain; target = (iters==0 ? 1 : iters); pass_cnt=0; ovf=0; go to EXEC.
- EXEC:
  - req_ready=0.
  - Each edge: result <= core output; pass_cnt += 1; ovf |= core[4] when op is 0 or 1; if chain, A <= core[3:0] (B, op unchanged).
  - When the incremented pass_cnt equals target, go to HOLD.
  - result is visible during EXEC but result_valid=0.
- HOLD:
  - result_valid=1, req_ready=0; result, ovf and pass_cnt are frozen.
  - result_ack=1 at an edge: go to IDLE and drop result_valid; result keeps its value.
- Latency: result_valid rises exactly N edges after the accept edge (N = effective passes). A new command can be accepted on the edge after the ack edge.
- Boundary conditions:
  - req_valid during EXEC or HOLD: ignored, no queueing.
  - result_ack outside HOLD: ignored.
  - Ack and a new req_valid on the same edge: ack only; the request is seen next cycle in IDLE.
  - iters = max value (7): 7 passes, pass_cnt ends at 7, no wrap.
  - chain=0 with iters>1: identical repeated passes; result equals the single-pass value.
  - Reset asserted mid-EXEC or mid-HOLD: abort immediately to reset values; no partial result retained.
- busy = (state != IDLE).

Decomposition:
- Shared package `alu_seq_pkg`:
  - op encodings: OP_ADD_RC=0, OP_ADD=1, OP_NANDXNOR=2, OP_ORRED=3, OP_PAR=4, OP_SWAPINV=5.
  - State encoding: IDLE, EXEC, HOLD.
  - Constants RES_ZERO=8'h00, RES_LO=8'h0F, RES_HI=8'hF0.
- One sub-module, `alu_core`: combinational (op, a, b) -> 8-bit result.
- The sequencer instantiates `alu_core` and contains only registers, the FSM and the counter.

Test Plan:
- Reset: hold resetn=0 for 2 cycles -> result=8'h00, result_valid=0, busy=0, req_ready=1, pass_cnt=0, ovf=0.
- Single pass: op0, a=4'h9, b=4'h8, iters=1, chain=0 -> result_valid one edge after accept; result=8'h11, ovf=1, pass_cnt=1; ack -> IDLE.
- Chained add: op0, a=3, b=5, iters=4, chain=1 -> result per pass 8'h08, 8'h0D, 8'h12, 8'h07; final result=8'h07, ovf=1, pass_cnt=4; valid 4 edges after accept.
- Logic ops, iters=0:
  - op2, a=4'hC, b=4'hA -> 8'h79, 1 pass.
  - op5, a=4'h3, b=4'hA -> 8'hAC.
  - op4, a=4'h5, b=4'h1 -> 8'hF0.
  - op3, a=0, b=0 -> 8'h00.
- Handshake: keep req_valid=1 through EXEC/HOLD with changing operands -> no re-accept, req_ready=0. Ack and req_valid on the same edge -> IDLE, then accept next edge. result_ack pulsed in IDLE -> no effect.
- Async reset mid-command: chain=1, iters=7; drop resetn after 3 passes, between edges -> outputs reach reset values without a clock edge; after release, a fresh command behaves normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings and constants for the ALU sequencer and its combinational core.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD_RC   = 3'd0;
    localparam logic [2:0] OP_ADD      = 3'd1;
    localparam logic [2:0] OP_NANDXNOR = 3'd2;
    localparam logic [2:0] OP_ORRED    = 3'd3;
    localparam logic [2:0] OP_PAR      = 3'd4;
    localparam logic [2:0] OP_SWAPINV  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [7:0] RES_ZERO = 8'h00;
    localparam logic [7:0] RES_LO   = 8'h0F;
    localparam logic [7:0] RES_HI   = 8'hF0;

endpackage

// File: rtl/alu_core.sv
// Combinational 4-bit ALU: maps (op, a, b) to an 8-bit result.
module alu_core
    import alu_seq_pkg::*;
(
    input  logic [2:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] y
);

    always_comb begin
        y = RES_ZERO;
        case (op)
            OP_ADD_RC,
            OP_ADD:      y = {3'b000, ({1'b0, a} + {1'b0, b})};
            OP_NANDXNOR: y = {~(a & b), ~(a ^ b)};
            OP_ORRED:    y = (|{a, b}) ? RES_LO : RES_ZERO;
            OP_PAR:      y = ((^b) && ($countones(a) == 2)) ? RES_HI : RES_ZERO;
            OP_SWAPINV:  y = {b, ~a};
            default:     y = RES_ZERO;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Accepts one ALU command per handshake, runs it for 1..2^ITER_W-1 passes and
// holds the 8-bit result until the consumer acknowledges it.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned ITER_W = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        op,
    input  logic [3:0]        a,
    input  logic [3:0]        b,
    input  logic [ITER_W-1:0] iters,
    input  logic              chain,
    output logic [7:0]        result,
    output logic              result_valid,
    input  logic              result_ack,
    output logic              busy,
    output logic [ITER_W-1:0] pass_cnt,
    output logic              ovf
);

    state_e              state_q, state_d;
    logic [3:0]          a_q, a_d;
    logic [3:0]          b_q, b_d;
    logic [2:0]          op_q, op_d;
    logic                chain_q, chain_d;
    logic [ITER_W-1:0]   target_q, target_d;
    logic [ITER_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [7:0]          result_q, result_d;
    logic                ovf_q, ovf_d;
    logic                req_ready_q, req_ready_d;
    logic                result_valid_q, result_valid_d;
    logic                busy_q, busy_d;

    logic [7:0]          core_y;
    logic [ITER_W-1:0]   pass_next;

    alu_core u_core (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (core_y)
    );

    assign pass_next = pass_cnt_q + ITER_W'(1);

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        chain_d        = chain_q;
        target_d       = target_q;
        pass_cnt_d     = pass_cnt_q;
        result_d       = result_q;
        ovf_d          = ovf_q;
        req_ready_d    = req_ready_q;
        result_valid_d = result_valid_q;
        busy_d         = busy_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d         = a;
                    b_d         = b;
                    op_d        = op;
                    chain_d     = chain;
                    target_d    = (iters == '0) ? ITER_W'(1) : iters;
                    pass_cnt_d  = '0;
                    ovf_d       = 1'b0;
                    state_d     = EXEC;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            EXEC: begin
                result_d   = core_y;
                pass_cnt_d = pass_next;
                if ((op_q == OP_ADD_RC) || (op_q == OP_ADD)) begin
                    ovf_d = ovf_q | core_y[4];
                end
                if (chain_q) begin
                    a_d = core_y[3:0];
                end
                if (pass_next == target_q) begin
                    state_d        = HOLD;
                    result_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (result_ack) begin
                    state_d        = IDLE;
                    result_valid_d = 1'b0;
                    busy_d         = 1'b0;
                    req_ready_d    = 1'b1;
                end
            end
            default: begin
                state_d        = IDLE;
                result_valid_d = 1'b0;
                busy_d         = 1'b0;
                req_ready_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            chain_q        <= 1'b0;
            target_q       <= '0;
            pass_cnt_q     <= '0;
            result_q       <= RES_ZERO;
            ovf_q          <= 1'b0;
            req_ready_q    <= 1'b1;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            chain_q        <= chain_d;
            target_q       <= target_d;
            pass_cnt_q     <= pass_cnt_d;
            result_q       <= result_d;
            ovf_q          <= ovf_d;
            req_ready_q    <= req_ready_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign pass_cnt     = pass_cnt_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a pass-by-pass arithmetic reference model.
module tb_alu_sequencer;

    localparam int unsigned ITER_W = 3;

    logic              clock = 1'b0;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        op;
    logic [3:0]        a;
    logic [3:0]        b;
    logic [ITER_W-1:0] iters;
    logic              chain;
    logic [7:0]        result;
    logic              result_valid;
    logic              result_ack;
    logic              busy;
    logic [ITER_W-1:0] pass_cnt;
    logic              ovf;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    alu_sequencer #(.ITER_W(ITER_W)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .op           (op),
        .a            (a),
        .b            (b),
        .iters        (iters),
        .chain        (chain),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .busy         (busy),
        .pass_cnt     (pass_cnt),
        .ovf          (ovf)
    );

    function automatic void model(input int op_i, input int a_i, input int b_i, input int it_i,
                                  input bit ch_i, output int res_o, output bit ov_o,
                                  output int passes_o);
        int av;
        int s;
        av       = a_i;
        passes_o = (it_i == 0) ? 1 : it_i;
        res_o    = 0;
        ov_o     = 1'b0;
        for (int p = 0; p < passes_o; p++) begin
            case (op_i)
                0, 1: begin
                    s     = av + b_i;
                    res_o = s;
                    if (s > 15) ov_o = 1'b1;
                end
                2: res_o = ((~(av & b_i)) & 15) * 16 + ((~(av ^ b_i)) & 15);
                3: res_o = (av != 0 || b_i != 0) ? 15 : 0;
                4: res_o = (($countones(b_i) % 2 == 1) && ($countones(av) == 2)) ? 240 : 0;
                5: res_o = b_i * 16 + (15 - av);
                default: res_o = 0;
            endcase
            if (ch_i) av = res_o % 16;
        end
    endfunction

    task automatic run_cmd(input int op_i, input int a_i, input int b_i, input int it_i,
                           input bit ch_i, output int lat);
        op        = 3'(op_i);
        a         = 4'(a_i);
        b         = 4'(b_i);
        iters     = ITER_W'(it_i);
        chain     = ch_i;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 0;
        while (result_valid !== 1'b1 && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        @(posedge clock); #1;
        result_ack = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = 1'b0; result_ack = 1'b0;
        op = '0; a = '0; b = '0; iters = '0; chain = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests++; if (result !== 8'h00) begin fails++; $display("FAIL reset_result got=%h exp=00", result); end
        tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        tests++; if (pass_cnt !== 3'd0) begin fails++; $display("FAIL reset_pass_cnt got=%0d exp=0", pass_cnt); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        resetn = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_single();
        int lat;
        run_cmd(0, 9, 8, 1, 1'b0, lat);
        tests++; if (lat != 1) begin fails++; $display("FAIL single_latency got=%0d exp=1", lat); end
        tests++; if (result !== 8'h11) begin fails++; $display("FAIL single_result got=%h exp=11", result); end
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL single_ovf got=%b exp=1", ovf); end
        tests++; if (pass_cnt !== 3'd1) begin fails++; $display("FAIL single_pass_cnt got=%0d exp=1", pass_cnt); end
        do_ack();
        tests++; if (result_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_ack valid=%b busy=%b exp=0/0", result_valid, busy); end
        tests++; if (result !== 8'h11) begin fails++; $display("FAIL single_result_kept got=%h exp=11", result); end
    endtask

    task automatic test_chain();
        logic [7:0] exp_pass [4];
        exp_pass[0] = 8'h08; exp_pass[1] = 8'h0D; exp_pass[2] = 8'h12; exp_pass[3] = 8'h07;
        op = 3'd0; a = 4'd3; b = 4'd5; iters = 3'd4; chain = 1'b1; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            tests++; if (result !== exp_pass[i]) begin fails++; $display("FAIL chain_pass%0d got=%h exp=%h", i, result, exp_pass[i]); end
            tests++; if (result_valid !== (i == 3)) begin fails++; $display("FAIL chain_valid%0d got=%b exp=%b", i, result_valid, (i == 3)); end
        end
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL chain_ovf got=%b exp=1", ovf); end
        tests++; if (pass_cnt !== 3'd4) begin fails++; $display("FAIL chain_pass_cnt got=%0d exp=4", pass_cnt); end
        do_ack();
    endtask

    task automatic test_logic();
        int tbl_op [4] = '{2, 5, 4, 3};
        int tbl_a  [4] = '{12, 3, 5, 0};
        int tbl_b  [4] = '{10, 10, 1, 0};
        int tbl_r  [4] = '{'h79, 'hAC, 'hF0, 'h00};
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_cmd(tbl_op[i], tbl_a[i], tbl_b[i], 0, 1'b0, lat);
            tests++; if (result !== 8'(tbl_r[i])) begin fails++; $display("FAIL logic_op%0d_result got=%h exp=%h", tbl_op[i], result, 8'(tbl_r[i])); end
            tests++; if (lat != 1 || pass_cnt !== 3'd1) begin fails++; $display("FAIL logic_op%0d_passes lat=%0d cnt=%0d exp=1/1", tbl_op[i], lat, pass_cnt); end
            do_ack();
        end
    endtask

    task automatic test_max_iters();
        int lat;
        run_cmd(0, 15, 15, 7, 1'b0, lat);
        tests++; if (lat != 7) begin fails++; $display("FAIL max_latency got=%0d exp=7", lat); end
        tests++; if (pass_cnt !== 3'd7) begin fails++; $display("FAIL max_pass_cnt got=%0d exp=7", pass_cnt); end
        tests++; if (result !== 8'h1E || ovf !== 1'b1) begin fails++; $display("FAIL max_result got=%h/%b exp=1e/1", result, ovf); end
        do_ack();
    endtask

    task automatic test_back_to_back();
        op = 3'd0; a = 4'd1; b = 4'd1; iters = 3'd3; chain = 1'b0; req_valid = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
            tests++; if (req_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL hs_exec%0d ready=%b busy=%b exp=0/1", i, req_ready, busy); end
            op = 3'($urandom_range(0, 7)); a = 4'($urandom); b = 4'($urandom);
            @(posedge clock); #1;
        end
        tests++; if (result_valid !== 1'b1 || result !== 8'h02 || pass_cnt !== 3'd3) begin fails++; $display("FAIL hs_done valid=%b res=%h cnt=%0d exp=1/02/3", result_valid, result, pass_cnt); end
        repeat (2) begin
            @(posedge clock); #1;
            tests++; if (result_valid !== 1'b1 || result !== 8'h02 || req_ready !== 1'b0) begin fails++; $display("FAIL hs_hold valid=%b res=%h ready=%b exp=1/02/0", result_valid, result, req_ready); end
        end
        op = 3'd5; a = 4'h3; b = 4'hA; iters = 3'd1; chain = 1'b0;
        result_ack = 1'b1;
        @(posedge clock); #1;
        result_ack = 1'b0;
        tests++; if (busy !== 1'b0 || req_ready !== 1'b1 || result !== 8'h02) begin fails++; $display("FAIL hs_ack_same_edge busy=%b ready=%b res=%h exp=0/1/02", busy, req_ready, result); end
        @(posedge clock); #1;
        req_valid = 1'b0;
        tests++; if (busy !== 1'b1 || req_ready !== 1'b0) begin fails++; $display("FAIL hs_accept_next busy=%b ready=%b exp=1/0", busy, req_ready); end
        @(posedge clock); #1;
        tests++; if (result_valid !== 1'b1 || result !== 8'hAC) begin fails++; $display("FAIL hs_second_cmd valid=%b res=%h exp=1/ac", result_valid, result); end
        do_ack();
        result_ack = 1'b1;
        @(posedge clock); #1;
        result_ack = 1'b0;
        tests++; if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 8'hAC) begin fails++; $display("FAIL hs_idle_ack busy=%b valid=%b res=%h exp=0/0/ac", busy, result_valid, result); end
    endtask

    task automatic test_async_reset();
        int lat;
        op = 3'd0; a = 4'd3; b = 4'd5; iters = 3'd7; chain = 1'b1; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        tests++; if (pass_cnt !== 3'd3 || result !== 8'h12) begin fails++; $display("FAIL arst_pre cnt=%0d res=%h exp=3/12", pass_cnt, result); end
        #2 resetn = 1'b0;
        #1;
        tests++; if (result !== 8'h00 || result_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL arst_outputs res=%h valid=%b busy=%b exp=00/0/0", result, result_valid, busy); end
        tests++; if (req_ready !== 1'b1 || pass_cnt !== 3'd0 || ovf !== 1'b0) begin fails++; $display("FAIL arst_ctrl ready=%b cnt=%0d ovf=%b exp=1/0/0", req_ready, pass_cnt, ovf); end
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        run_cmd(2, 12, 10, 0, 1'b0, lat);
        tests++; if (lat != 1 || result !== 8'h79 || ovf !== 1'b0) begin fails++; $display("FAIL arst_fresh lat=%0d res=%h ovf=%b exp=1/79/0", lat, result, ovf); end
        do_ack();
    endtask

    task automatic test_random();
        int op_r, a_r, b_r, it_r, lat, exp_res, exp_n;
        bit ch_r, exp_ov;
        for (int n = 0; n < 40; n++) begin
            op_r = $urandom_range(0, 7);
            a_r  = $urandom_range(0, 15);
            b_r  = $urandom_range(0, 15);
            it_r = $urandom_range(0, 7);
            ch_r = 1'($urandom_range(0, 1));
            model(op_r, a_r, b_r, it_r, ch_r, exp_res, exp_ov, exp_n);
            run_cmd(op_r, a_r, b_r, it_r, ch_r, lat);
            tests++; if (lat != exp_n) begin fails++; $display("FAIL rand%0d_latency got=%0d exp=%0d", n, lat, exp_n); end
            tests++; if (result !== 8'(exp_res)) begin fails++; $display("FAIL rand%0d_result op=%0d a=%0d b=%0d it=%0d ch=%0d got=%h exp=%h", n, op_r, a_r, b_r, it_r, ch_r, result, 8'(exp_res)); end
            tests++; if (ovf !== exp_ov) begin fails++; $display("FAIL rand%0d_ovf got=%b exp=%b", n, ovf, exp_ov); end
            tests++; if (pass_cnt !== ITER_W'(exp_n)) begin fails++; $display("FAIL rand%0d_pass_cnt got=%0d exp=%0d", n, pass_cnt, exp_n); end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
            tests++; if (result_valid !== 1'b1 || req_ready !== 1'b0) begin fails++; $display("FAIL rand%0d_hold valid=%b ready=%b exp=1/0", n, result_valid, req_ready); end
            do_ack();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_chain();
        test_logic();
        test_max_iters();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
